riscv_lsu: RTL and testbench

- Load/store unit directly upstream of the byte-addressed data RAM port (addr, write_en, wdata, ram_mask_sel, dout). That RAM has combinational read and a synchronous write on posedge clk.
- Accepts one memory request at a time from the execute stage and drives the RAM data port.
- Splits misaligned halfword/word accesses into sequential byte accesses.
- Sign- or zero-extends load data and returns a one-cycle response to writeback.

---
 rtl/riscv_lsu.sv | 171 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | riscv_lsu : RV32I load/store unit driving a byte-addressed RAM port; splits  |
// | misaligned H/W accesses into byte accesses. RISCV_LSU_MISALIGN_TRAP_EN traps |
// | misaligned requests instead. Rev 1.0                                         |
// +-----------------------------------------------------------------------------+
module riscv_lsu #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_store,
  input  logic [2:0]             req_funct3,
  input  logic [ADDR_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic                   resp_err,
  output logic [ADDR_LENGTH-1:0] ram_addr,
  output logic                   ram_write_en,
  output logic [WORD_LENGTH-1:0] ram_wdata,
  output logic [1:0]             ram_mask_sel,
  input  logic [WORD_LENGTH-1:0] ram_dout
);

  localparam logic [1:0] MASK_B = 2'd0;
  localparam logic [1:0] MASK_H = 2'd1;
  localparam logic [1:0] MASK_X = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                   store_q;
  logic [2:0]             funct3_q;
  logic [ADDR_LENGTH-1:0] addr_q;
  logic [WORD_LENGTH-1:0] wdata_q;
  logic                   misal_q;
  logic                   err_q;
  logic [1:0]             k;
  logic [1:0]             k_nxt;
  logic [1:0]             last_k;
  logic [WORD_LENGTH-1:0] asm_q;
  logic [ADDR_LENGTH-1:0] addr_r;
  logic [WORD_LENGTH-1:0] wdata_r;
  logic [1:0]             mask_r;

  logic       accept;
  logic       req_invalid;
  logic       req_misal;
  logic       req_err;
  logic [1:0] req_mask;

  // Decode of the incoming request, used only on the accepting cycle.
  always_comb begin
    accept    = req_valid && (state == IDLE);
    req_misal = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
    if (req_store) req_invalid = (req_funct3 >= 3'd3);
    else           req_invalid = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    req_err = req_invalid || req_misal;
`else
    req_err = req_invalid;
`endif
    case (req_funct3[1:0])
      2'd0:    req_mask = MASK_B;
      2'd1:    req_mask = req_misal ? MASK_B : MASK_H;
      default: req_mask = req_misal ? MASK_B : MASK_X;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'd0:    last_k = 2'd0;
      2'd1:    last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
    k_nxt = k + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  if (!misal_q || (k == last_k)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM-side outputs are registered one step ahead so they hold outside ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      misal_q  <= 1'b0;
      err_q    <= 1'b0;
      k        <= 2'd0;
      asm_q    <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
      mask_r   <= MASK_X;
    end else begin
      if (accept) begin
        store_q  <= req_store;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        misal_q  <= req_misal;
        err_q    <= req_err;
        k        <= 2'd0;
        if (!req_err) begin
          addr_r  <= req_addr;
          wdata_r <= req_wdata;
          mask_r  <= req_mask;
        end
      end
      if (state == ACCESS) begin
        if (misal_q) begin
          asm_q[{k, 3'b000} +: 8] <= ram_dout[7:0];
          k <= k_nxt;
          if (k != last_k) begin
            addr_r  <= addr_q + ADDR_LENGTH'(k_nxt);
            wdata_r <= wdata_q >> {k_nxt, 3'b000};
          end
        end else begin
          asm_q <= ram_dout;
        end
      end
    end
  end

  always_comb begin
    resp_rdata = '0;
    if ((state == RESP) && !err_q && !store_q) begin
      case (funct3_q)
        3'd0:    resp_rdata = {{(WORD_LENGTH-8){asm_q[7]}}, asm_q[7:0]};
        3'd4:    resp_rdata = {{(WORD_LENGTH-8){1'b0}}, asm_q[7:0]};
        3'd1:    resp_rdata = {{(WORD_LENGTH-16){asm_q[15]}}, asm_q[15:0]};
        3'd5:    resp_rdata = {{(WORD_LENGTH-16){1'b0}}, asm_q[15:0]};
        3'd2:    resp_rdata = asm_q;
        default: resp_rdata = '0;
      endcase
    end
  end

  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == RESP);
  assign resp_err     = (state == RESP) && err_q;
  assign ram_write_en = (state == ACCESS) && store_q && !rst;
  assign ram_addr     = addr_r;
  assign ram_wdata    = wdata_r;
  assign ram_mask_sel = mask_r;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// tb_riscv_lsu: directed vector table plus randomized requests checked against a
// byte-array reference model of the RAM and the RV32I load/store rules.
module tb_riscv_lsu;

  localparam logic [1:0] MASK_B = 2'd0;
  localparam logic [1:0] MASK_H = 2'd1;
  localparam logic [1:0] MASK_X = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_dout;
  logic        ram_write_en;
  logic [1:0]  ram_mask_sel;

  always #5 clk = ~clk;

  riscv_lsu #(.WORD_LENGTH(32), .ADDR_LENGTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_write_en(ram_write_en), .ram_wdata(ram_wdata),
    .ram_mask_sel(ram_mask_sel), .ram_dout(ram_dout)
  );

  // RAM model: 1 KiB, address bits above 9 ignored, combinational read.
  logic [7:0] mem [0:1023];
  logic       clear_mem;
  logic [31:0] a1, a2, a3;
  always_comb begin
    a1 = ram_addr + 32'd1;
    a2 = ram_addr + 32'd2;
    a3 = ram_addr + 32'd3;
    ram_dout = {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[ram_addr[9:0]]};
  end
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (ram_write_en) begin
      mem[ram_addr[9:0]] <= ram_wdata[7:0];
      if (ram_mask_sel != MASK_B) mem[a1[9:0]] <= ram_wdata[15:8];
      if (ram_mask_sel == MASK_X) begin
        mem[a2[9:0]] <= ram_wdata[23:16];
        mem[a3[9:0]] <= ram_wdata[31:24];
      end
    end
  end

  logic [7:0]  ref_mem [0:1023];
  logic [31:0] acc_addr [8];
  logic [1:0]  acc_mask [8];
  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: N bytes at addr..addr+N-1, little-endian, extension by funct3.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int wes);
    int n;
    logic mis;
    logic [31:0] word, ea;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    er  = st ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 >= 3'd6));
    mis = (a % 32'(n)) != 0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    if (mis) er = 1'b1;
`endif
    rd = 32'h0; wes = 0;
    if (er) begin
      lat = 1;
    end else begin
      lat = mis ? n + 1 : 2;
      word = 32'h0;
      for (int i = 0; i < n; i++) begin
        ea = a + 32'(i);
        if (st) ref_mem[ea[9:0]] = 8'(wd >> (8 * i));
        else    word = word | (32'(ref_mem[ea[9:0]]) << (8 * i));
      end
      if (st) begin
        wes = mis ? n : 1;
      end else begin
        if (!f3[2] && n < 4 && word[8*n-1]) word = word | (32'hFFFFFFFF << (8 * n));
        rd = word;
      end
    end
  endtask

  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit noise,
                         output logic [31:0] rd, output logic er, output int lat, output int wes);
    int c, busy_rdy;
    @(negedge clk);
    check("ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (noise) begin
      req_store = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
    end
    rd = 32'h0; er = 1'b0; lat = 0; wes = 0; c = 0; busy_rdy = 0;
    while (lat == 0 && c < 12) begin
      @(negedge clk);
      c++;
      if (req_ready) busy_rdy++;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err; req_valid = 1'b0;
      end else begin
        if (ram_write_en) wes++;
        if (c <= 8) begin
          acc_addr[c-1] = ram_addr;
          acc_mask[c-1] = ram_mask_sel;
        end
      end
    end
    req_valid = 1'b0;
    check("ready_busy", 32'(busy_rdy), 32'h0);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wes;
    logic        chk_mask;
    logic [1:0]  mask0;
  } vec_t;

  vec_t vt [12];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, wes, mlat, mwes, seen, bad;
    logic st;
    logic [2:0] f3;
    logic [31:0] a, wd;

    vt[0]  = '{1'b1, 3'd2, 32'h100, 32'h94832211, 32'h0, 1'b0, 2, 1, 1'b1, MASK_X};
    vt[1]  = '{1'b0, 3'd0, 32'h102, 32'h0, 32'hFFFFFF83, 1'b0, 2, 0, 1'b1, MASK_B};
    vt[2]  = '{1'b0, 3'd4, 32'h102, 32'h0, 32'h00000083, 1'b0, 2, 0, 1'b0, MASK_B};
    vt[3]  = '{1'b0, 3'd1, 32'h102, 32'h0, 32'hFFFF9483, 1'b0, 2, 0, 1'b1, MASK_H};
    vt[4]  = '{1'b0, 3'd5, 32'h102, 32'h0, 32'h00009483, 1'b0, 2, 0, 1'b0, MASK_H};
    vt[5]  = '{1'b1, 3'd0, 32'h104, 32'h000000AA, 32'h0, 1'b0, 2, 1, 1'b1, MASK_B};
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    vt[6]  = '{1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0, MASK_B};
    vt[7]  = '{1'b1, 3'd1, 32'h103, 32'h0000BEEF, 32'h0, 1'b1, 1, 0, 1'b0, MASK_B};
    vt[8]  = '{1'b0, 3'd5, 32'h103, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0, MASK_B};
    vt[11] = '{1'b0, 3'd2, 32'h100, 32'h0, 32'h94832211, 1'b0, 2, 0, 1'b1, MASK_X};
`else
    vt[6]  = '{1'b0, 3'd2, 32'h101, 32'h0, 32'hAA948322, 1'b0, 5, 0, 1'b1, MASK_B};
    vt[7]  = '{1'b1, 3'd1, 32'h103, 32'h0000BEEF, 32'h0, 1'b0, 3, 2, 1'b1, MASK_B};
    vt[8]  = '{1'b0, 3'd5, 32'h103, 32'h0, 32'h0000BEEF, 1'b0, 3, 0, 1'b0, MASK_B};
    vt[11] = '{1'b0, 3'd2, 32'h100, 32'h0, 32'hEF832211, 1'b0, 2, 0, 1'b1, MASK_X};
`endif
    vt[9]  = '{1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0, MASK_B};
    vt[10] = '{1'b1, 3'd4, 32'h100, 32'h12345678, 32'h0, 1'b1, 1, 0, 1'b0, MASK_B};

    rst = 1'b1; clear_mem = 1'b1; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_ram", {29'h0, ram_write_en, ram_mask_sel}, {29'h0, 1'b0, MASK_X});
    check("rst_ram_addr", ram_addr | ram_wdata, 32'h0);
    rst = 1'b0; clear_mem = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_req(vt[i].st, vt[i].f3, vt[i].a, vt[i].wd, 1'b0, rd, er, lat, wes);
      model(vt[i].st, vt[i].f3, vt[i].a, vt[i].wd, mrd, mer, mlat, mwes);
      check($sformatf("v%0d_rdata", i), rd, vt[i].rd);
      check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vt[i].er});
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("v%0d_wes", i), 32'(wes), 32'(vt[i].wes));
      if (vt[i].chk_mask) check($sformatf("v%0d_mask", i), {30'h0, acc_mask[0]}, {30'h0, vt[i].mask0});
    end

`ifndef RISCV_LSU_MISALIGN_TRAP_EN
    // Misaligned LW walks four byte addresses with byte masks.
    run_req(1'b0, 3'd2, 32'h101, 32'h0, 1'b0, rd, er, lat, wes);
    check("mlw_rdata", rd, 32'hBEEF8322);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mlw_addr%0d", i), acc_addr[i], 32'h101 + 32'(i));
      check($sformatf("mlw_mask%0d", i), {30'h0, acc_mask[i]}, {30'h0, MASK_B});
    end

    // Reset in the second ACCESS cycle of a misaligned SW abandons the store.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h101; req_wdata = 32'h44332211;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rseq_we_k0", {31'h0, ram_write_en}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rseq_we_gated", {31'h0, ram_write_en}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("rseq_ready", {31'h0, req_ready}, 32'h1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("rseq_no_resp", 32'(seen), 32'h0);
    check("rseq_b101", {24'h0, mem[10'h101]}, 32'h11);
    check("rseq_b102", {24'h0, mem[10'h102]}, 32'h83);
    ref_mem[10'h101] = 8'h11;
`endif

    for (int t = 0; t < 150; t++) begin
      st = 1'($urandom);
      f3 = 3'($urandom);
      wd = $urandom;
      a  = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                        : 32'($urandom_range(0, 1019));
      model(st, f3, a, wd, mrd, mer, mlat, mwes);
      run_req(st, f3, a, wd, 1'b1, rd, er, lat, wes);
      check($sformatf("r%0d_rdata", t), rd, mrd);
      check($sformatf("r%0d_err", t), {31'h0, er}, {31'h0, mer});
      check($sformatf("r%0d_lat", t), 32'(lat), 32'(mlat));
      check($sformatf("r%0d_wes", t), 32'(wes), 32'(mwes));
    end

    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", 32'(bad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
